// File: rtl/ternary_mvm_pkg.sv
// Shared constants, state encoding and size helpers for the ternary matrix-vector engine.
// Combinational definitions only; no latency and no handshake of its own.
package ternary_mvm_pkg;

    localparam logic [1:0] W_ZERO = 2'b00;
    localparam logic [1:0] W_POS  = 2'b01;
    localparam logic [1:0] W_NEG  = 2'b11;
    localparam logic [1:0] W_RSVD = 2'b10;

    localparam logic OP_LOAD = 1'b0;
    localparam logic OP_MULT = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_MAC,
        ST_DRAIN
    } state_e;

    function automatic int acc_width(input int in_w, input int in_len);
        return in_w + $clog2(in_len) + 1;
    endfunction

    function automatic int load_beats(input int in_w, input int in_len, input int out_len);
        return (2 * in_len * out_len + 2 * in_w - 1) / (2 * in_w);
    endfunction

endpackage

// File: rtl/ternary_mac_row.sv
// One output row: accumulates two ternary-weighted elements per enabled beat.
// One-cycle update, no handshake; acc_nxt is the value the row will hold after this edge.
module ternary_mac_row
    import ternary_mvm_pkg::*;
#(
    parameter int IN_W  = 8,
    parameter int ACC_W = 13
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                en,
    input  logic [3:0]          w_pair,
    input  logic [2*IN_W-1:0]   x_pair,
    output logic [ACC_W-1:0]    acc_nxt
);

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;

    always_comb begin : mac_sum
        logic [IN_W-1:0]  x;
        logic [ACC_W-1:0] xe;
        acc_d = acc_q;
        x     = '0;
        xe    = '0;
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            for (int j = 0; j < 2; j++) begin
                x  = x_pair[j*IN_W +: IN_W];
                xe = {{(ACC_W-IN_W){x[IN_W-1]}}, x};
                case (w_pair[2*j +: 2])
                    W_POS:   acc_d = acc_d + xe;
                    W_NEG:   acc_d = acc_d - xe;
                    default: acc_d = acc_d;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_nxt = acc_d;

endmodule

// File: rtl/ternary_mvm_engine.sv
// Ternary-weight matrix-vector engine: LOAD packed 2-bit weights, MULT streams a vector, DRAIN emits saturated rows.
// First result 1 cycle after the last MAC beat; out_data/out_idx hold while out_ready is low.
module ternary_mvm_engine
    import ternary_mvm_pkg::*;
#(
    parameter int IN_LEN  = 14,
    parameter int OUT_LEN = 7,
    parameter int IN_W    = 8,
    parameter int OUT_W   = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_valid,
    input  logic                cmd_op,
    output logic                cmd_ready,
    input  logic [2*IN_W-1:0]   in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [OUT_W-1:0]    out_data,
    output logic [((OUT_LEN > 1) ? $clog2(OUT_LEN) : 1)-1:0] out_idx,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                busy
);

    localparam int ACC_W      = acc_width(IN_W, IN_LEN);
    localparam int N_WTS      = IN_LEN * OUT_LEN;
    localparam int LOAD_BEATS = load_beats(IN_W, IN_LEN, OUT_LEN);
    localparam int MAC_BEATS  = IN_LEN / 2;
    localparam int CNT_MAX    = (LOAD_BEATS > MAC_BEATS) ? LOAD_BEATS : MAC_BEATS;
    localparam int CNT_W      = $clog2(CNT_MAX + 1);
    localparam int IDX_W      = (OUT_LEN > 1) ? $clog2(OUT_LEN) : 1;

    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    function automatic logic [OUT_W-1:0] sat(input logic signed [ACC_W-1:0] a);
        if (a > SAT_MAX) return SAT_MAX[OUT_W-1:0];
        if (a < SAT_MIN) return SAT_MIN[OUT_W-1:0];
        return a[OUT_W-1:0];
    endfunction

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*N_WTS-1:0] w_q, w_d;
    logic               out_valid_q, out_valid_d;
    logic [OUT_W-1:0]   out_data_q, out_data_d;
    logic [IDX_W-1:0]   out_idx_q, out_idx_d;
    logic               cmd_ready_q, cmd_ready_d;
    logic               in_ready_q, in_ready_d;
    logic               busy_q, busy_d;
    logic               acc_clr, acc_en;
    logic [ACC_W-1:0]   acc_nxt [OUT_LEN];

    for (genvar r = 0; r < OUT_LEN; r++) begin : g_row
        ternary_mac_row #(
            .IN_W  (IN_W),
            .ACC_W (ACC_W)
        ) u_row (
            .clk     (clk),
            .rst_n   (rst_n),
            .clr     (acc_clr),
            .en      (acc_en),
            .w_pair  (w_q[r*2*IN_LEN + int'(cnt_q)*4 +: 4]),
            .x_pair  (in_data),
            .acc_nxt (acc_nxt[r])
        );
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        w_d         = w_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_idx_d   = out_idx_q;
        acc_clr     = 1'b0;
        acc_en      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    cnt_d = '0;
                    if (cmd_op == OP_LOAD) begin
                        state_d = ST_LOAD;
                    end else begin
                        state_d = ST_MAC;
                        acc_clr = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                if (in_valid && in_ready_q) begin
                    // Row-major weight i lives in beat i/IN_W; padding of the last beat is dropped.
                    for (int i = 0; i < N_WTS; i++) begin
                        if (cnt_q == CNT_W'(i / IN_W)) w_d[2*i +: 2] = in_data[2*(i % IN_W) +: 2];
                    end
                    if (cnt_q == CNT_W'(LOAD_BEATS - 1)) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_MAC: begin
                if (in_valid && in_ready_q) begin
                    acc_en = 1'b1;
                    if (cnt_q == CNT_W'(MAC_BEATS - 1)) begin
                        state_d     = ST_DRAIN;
                        cnt_d       = '0;
                        out_valid_d = 1'b1;
                        out_idx_d   = '0;
                        out_data_d  = sat(acc_nxt[0]);
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (out_ready) begin
                    if (out_idx_q == IDX_W'(OUT_LEN - 1)) begin
                        state_d     = ST_IDLE;
                        out_valid_d = 1'b0;
                    end else begin
                        out_idx_d  = out_idx_q + IDX_W'(1);
                        out_data_d = sat(acc_nxt[int'(out_idx_q) + 1]);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        cmd_ready_d = (state_d == ST_IDLE);
        in_ready_d  = (state_d == ST_LOAD) || (state_d == ST_MAC);
        busy_d      = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            w_q         <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
            cmd_ready_q <= 1'b1;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            w_q         <= w_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_idx_q   <= out_idx_d;
            cmd_ready_q <= cmd_ready_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_idx   = out_idx_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_ternary_mvm_engine.sv
// Randomized bench for ternary_mvm_engine: expected rows come from a plain integer matrix model,
// pushed into a scoreboard queue and popped by an independent output monitor.
module tb_ternary_mvm_engine;

    localparam int IN_LEN    = 14;
    localparam int OUT_LEN   = 7;
    localparam int IN_W      = 8;
    localparam int OUT_W     = 8;
    localparam int BW        = 2 * IN_W;
    localparam int N_BEATS   = (2 * IN_LEN * OUT_LEN + BW - 1) / BW;
    localparam int MAC_BEATS = IN_LEN / 2;

    typedef int vec_t [IN_LEN];

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_op = 1'b0;
    logic             cmd_ready;
    logic [BW-1:0]    in_data = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [OUT_W-1:0] out_data;
    logic [2:0]       out_idx;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic             busy;

    int n_checks = 0;
    int n_pass   = 0;
    int wm [OUT_LEN][IN_LEN];
    int exp_idx_q [$];
    int exp_dat_q [$];
    int mon_i, mon_d;

    ternary_mvm_engine #(
        .IN_LEN  (IN_LEN),
        .OUT_LEN (OUT_LEN),
        .IN_W    (IN_W),
        .OUT_W   (OUT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_op    (cmd_op),
        .cmd_ready (cmd_ready),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input bit ok, input string name, input int act, input int exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_dat_q.size() == 0) begin
                chk(1'b0, "unexpected_result", int'(out_idx), -1);
            end else begin
                mon_i = exp_idx_q.pop_front();
                mon_d = exp_dat_q.pop_front();
                chk(int'(out_idx) == mon_i, "out_idx", int'(out_idx), mon_i);
                chk(int'($signed(out_data)) == mon_d, "out_data", int'($signed(out_data)), mon_d);
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        for (int r = 0; r < OUT_LEN; r++)
            for (int c = 0; c < IN_LEN; c++) wm[r][c] = 0;
    endtask

    task automatic check_reset_vals();
        chk(cmd_ready == 1'b1, "rst_cmd_ready", int'(cmd_ready), 1);
        chk(in_ready == 1'b0, "rst_in_ready", int'(in_ready), 0);
        chk(out_valid == 1'b0, "rst_out_valid", int'(out_valid), 0);
        chk(busy == 1'b0, "rst_busy", int'(busy), 0);
        chk(out_data == '0, "rst_out_data", int'(out_data), 0);
        chk(out_idx == '0, "rst_out_idx", int'(out_idx), 0);
    endtask

    task automatic send_cmd(input logic op);
        bit ok = 1'b0;
        cmd_op = op;
        for (int i = 0; i < 200 && !ok; i++) begin
            ok = cmd_ready;
            cmd_valid = ok;
            tick();
        end
        cmd_valid = 1'b0;
        if (!ok) chk(1'b0, "cmd_timeout", 0, 1);
    endtask

    task automatic wait_beat();
        bit done = 1'b0;
        for (int i = 0; i < 50 && !done; i++) begin
            done = in_ready;
            tick();
        end
        if (!done) chk(1'b0, "beat_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
        if (busy) chk(1'b0, "drain_timeout", n, 200);
    endtask

    // Packs the model matrix (row-major, 2-bit codes) into beats; padding bits are random junk.
    task automatic load_weights(input int n_send);
        logic [N_BEATS*BW-1:0] pk;
        logic [1:0] code;
        for (int b = 0; b < N_BEATS; b++) pk[b*BW +: BW] = BW'($urandom());
        for (int r = 0; r < OUT_LEN; r++) begin
            for (int c = 0; c < IN_LEN; c++) begin
                if (wm[r][c] == 1) code = 2'b01;
                else if (wm[r][c] == -1) code = 2'b11;
                else code = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b00;
                pk[2*(r*IN_LEN + c) +: 2] = code;
            end
        end
        send_cmd(1'b0);
        for (int b = 0; b < n_send; b++) begin
            in_valid = 1'b1;
            in_data = pk[b*BW +: BW];
            wait_beat();
        end
        in_valid = 1'b0;
        if (n_send == N_BEATS) chk(cmd_ready && !busy, "load_done_idle", int'(busy), 0);
    endtask

    task automatic send_x(input vec_t x, input bit gaps, input bit noise);
        logic [IN_W-1:0] lo, hi;
        for (int k = 0; k < MAC_BEATS; k++) begin
            if (gaps) begin
                in_valid = 1'b0;
                tick();
            end
            lo = IN_W'(x[2*k]);
            hi = IN_W'(x[2*k+1]);
            in_valid = 1'b1;
            in_data = {hi, lo};
            cmd_valid = noise;
            cmd_op = 1'($urandom_range(0, 1));
            wait_beat();
        end
        in_valid = 1'b0;
        cmd_valid = 1'b0;
    endtask

    task automatic push_expected(input vec_t x);
        int y;
        for (int r = 0; r < OUT_LEN; r++) begin
            y = 0;
            for (int c = 0; c < IN_LEN; c++) y += wm[r][c] * x[c];
            if (y > 127) y = 127;
            if (y < -128) y = -128;
            exp_idx_q.push_back(r);
            exp_dat_q.push_back(y);
        end
    endtask

    task automatic run_mult(input vec_t x, input bit gaps, input bit bp, input bit noise);
        logic [OUT_W-1:0] hd;
        logic [2:0] hi;
        int n;
        push_expected(x);
        send_cmd(1'b1);
        send_x(x, gaps, noise);
        chk(out_valid == 1'b1, "first_result_latency", int'(out_valid), 1);
        if (!bp) begin
            repeat (OUT_LEN) tick();
            chk(!busy && cmd_ready, "drain_in_out_len_cycles", int'(busy), 0);
        end else begin
            n = 0;
            while (!(out_valid && out_idx == 3'd2) && n < 50) begin
                tick();
                n++;
            end
            out_ready = 1'b0;
            hd = out_data;
            hi = out_idx;
            chk(hi == 3'd2, "bp_row", int'(hi), 2);
            repeat (5) begin
                tick();
                chk(out_valid && out_data == hd && out_idx == hi, "bp_hold",
                    int'(out_data), int'(hd));
            end
            out_ready = 1'b1;
            wait_idle();
        end
    endtask

    function automatic vec_t rand_vec();
        vec_t v;
        for (int c = 0; c < IN_LEN; c++) v[c] = int'($urandom_range(0, 255)) - 128;
        return v;
    endfunction

    task automatic rand_weights();
        for (int r = 0; r < OUT_LEN; r++)
            for (int c = 0; c < IN_LEN; c++) wm[r][c] = int'($urandom_range(0, 2)) - 1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        vec_t x, x2;

        do_reset();
        check_reset_vals();

        // MULT before any LOAD: all-zero weights.
        run_mult(rand_vec(), 1'b0, 1'b0, 1'b0);

        // All +1 weights, all elements 3 -> 42 per row.
        for (int r = 0; r < OUT_LEN; r++)
            for (int c = 0; c < IN_LEN; c++) wm[r][c] = 1;
        load_weights(N_BEATS);
        for (int c = 0; c < IN_LEN; c++) x[c] = 3;
        run_mult(x, 1'b0, 1'b0, 1'b0);

        // Row 0 all -1, others 0, elements -128 -> row 0 saturates to 127.
        for (int r = 0; r < OUT_LEN; r++)
            for (int c = 0; c < IN_LEN; c++) wm[r][c] = (r == 0) ? -1 : 0;
        load_weights(N_BEATS);
        for (int c = 0; c < IN_LEN; c++) x[c] = -128;
        run_mult(x, 1'b0, 1'b0, 1'b0);

        // Random weights: continuous vs gapped input, back-pressure, ignored commands.
        rand_weights();
        load_weights(N_BEATS);
        x = rand_vec();
        run_mult(x, 1'b0, 1'b0, 1'b0);
        run_mult(x, 1'b1, 1'b0, 1'b0);
        run_mult(x, 1'b0, 1'b1, 1'b1);

        // Back-to-back MULTs on retained weights.
        x2 = rand_vec();
        run_mult(x2, 1'b0, 1'b0, 1'b0);
        run_mult(rand_vec(), 1'b1, 1'b0, 1'b1);

        for (int t = 0; t < 4; t++) begin
            rand_weights();
            load_weights(N_BEATS);
            run_mult(rand_vec(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
        end

        // Reset mid-DRAIN: results dropped, weights cleared.
        out_ready = 1'b0;
        send_cmd(1'b1);
        send_x(rand_vec(), 1'b0, 1'b0);
        tick();
        chk(out_valid == 1'b1 && busy, "drain_stalled", int'(out_valid), 1);
        do_reset();
        out_ready = 1'b1;
        check_reset_vals();
        run_mult(rand_vec(), 1'b0, 1'b0, 1'b0);

        // Reset after 6 LOAD beats: no partial weights survive.
        for (int r = 0; r < OUT_LEN; r++)
            for (int c = 0; c < IN_LEN; c++) wm[r][c] = 1;
        load_weights(6);
        do_reset();
        check_reset_vals();
        run_mult(rand_vec(), 1'b0, 1'b0, 1'b0);

        repeat (3) tick();
        chk(exp_dat_q.size() == 0, "results_outstanding", exp_dat_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
